ram1_arbiter: RTL and testbench



---
 rtl/ram1_arbiter_pkg.sv | 20 ++
 rtl/ram1_arbiter.sv | 134 +++++++++++++
 tb/tb_ram1_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram1_arbiter_pkg.sv
// Shared definitions for the Ram1 fixed-priority arbiter: state encoding,
// grant identifiers and default widths.
package ram1_arbiter_pkg;

  localparam int DATA_W     = 16;
  localparam int CPU_ADDR_W = 16;
  localparam int RAM_ADDR_W = 18;

  localparam logic [1:0] ADDR_EXT_DEFAULT = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/ram1_arbiter.sv
// Fixed-priority (MEM over IF) arbiter and three-cycle sequencer in front of
// the Ram1 SRAM driver; every driver input and requester output is registered.
module ram1_arbiter #(
  parameter logic [1:0] ADDR_EXT = ram1_arbiter_pkg::ADDR_EXT_DEFAULT,
  parameter int         DATA_W   = ram1_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              busy,
  output logic [17:0]       ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_rdata
);
  import ram1_arbiter_pkg::*;

  state_t                  state_r;
  state_t                  state_s;
  logic                    grant_s;
  logic                    gnt_id_s;
  logic                    req_wr_s;
  logic [RAM_ADDR_W-1:0]   req_addr_s;
  logic [DATA_W-1:0]       req_wdata_s;

  logic                    gnt_r;
  logic                    wr_r;
  logic                    busy_r;
  logic                    if_done_r;
  logic                    mem_done_r;
  logic [DATA_W-1:0]       if_rdata_r;
  logic [DATA_W-1:0]       mem_rdata_r;
  logic [RAM_ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]       ram_data_r;
  logic                    ram_wr_r;

  // Next-state and grant selection; requests are only looked at in IDLE.
  always_comb begin
    state_s     = state_r;
    grant_s     = 1'b0;
    gnt_id_s    = GNT_IF;
    req_wr_s    = 1'b0;
    req_addr_s  = {ADDR_EXT, if_addr};
    req_wdata_s = ram_data_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_req) begin
          grant_s     = 1'b1;
          gnt_id_s    = GNT_MEM;
          req_wr_s    = mem_wr;
          req_addr_s  = {ADDR_EXT, mem_addr};
          req_wdata_s = mem_wdata;
          state_s     = ST_ACCESS;
        end else if (if_req) begin
          grant_s = 1'b1;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS:  state_s = ST_CAPTURE;
      ST_CAPTURE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // State register and busy flag, both tracking the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Latched request, driver inputs, done pulses and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r       <= GNT_IF;
      wr_r        <= 1'b0;
      ram_addr_r  <= {RAM_ADDR_W{1'b0}};
      ram_data_r  <= {DATA_W{1'b0}};
      ram_wr_r    <= 1'b0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      mem_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if_done_r  <= 1'b0;
      mem_done_r <= 1'b0;
      ram_wr_r   <= 1'b0;
      if (grant_s) begin
        gnt_r      <= gnt_id_s;
        wr_r       <= req_wr_s;
        ram_addr_r <= req_addr_s;
        ram_data_r <= req_wdata_s;
        ram_wr_r   <= req_wr_s;
      end
      // The driver latched ram_rdata at the ACCESS negedge, so it is stable here.
      if (state_r == ST_ACCESS) begin
        if (gnt_r == GNT_MEM) begin
          mem_done_r <= 1'b1;
          if (!wr_r) begin
            mem_rdata_r <= ram_rdata;
          end
        end else begin
          if_done_r  <= 1'b1;
          if_rdata_r <= ram_rdata;
        end
      end
    end
  end

  assign if_rdata  = if_rdata_r;
  assign if_done   = if_done_r;
  assign mem_rdata = mem_rdata_r;
  assign mem_done  = mem_done_r;
  assign busy      = busy_r;
  assign ram_addr  = ram_addr_r;
  assign ram_data  = ram_data_r;
  assign ram_wr    = ram_wr_r;

endmodule

// File: tb/tb_ram1_arbiter.sv
// Bench for ram1_arbiter: SRAM stand-in, transaction-level reference model
// with per-cycle comparison, directed literal checks and randomized traffic.
module tb_ram1_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] mem_wdata = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        busy;
  logic [17:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_wr;
  logic [15:0] ram_rdata = 16'h0000;

  // second instance with a non-zero address extension
  logic        if_req3 = 1'b0;
  logic [15:0] if_addr3 = 16'h0000;
  logic [15:0] if_rdata3;
  logic        if_done3;
  logic        mem_req3 = 1'b0;
  logic        mem_wr3 = 1'b0;
  logic [15:0] mem_addr3 = 16'h0000;
  logic [15:0] mem_wdata3 = 16'h0000;
  logic [15:0] mem_rdata3;
  logic        mem_done3;
  logic        busy3;
  logic [17:0] ram_addr3;
  logic [15:0] ram_data3;
  logic        ram_wr3;
  logic [15:0] ram_rdata3 = 16'h1234;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram1_arbiter u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr), .ram_rdata(ram_rdata)
  );

  ram1_arbiter #(.ADDR_EXT(2'b11)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_done(if_done3),
    .mem_req(mem_req3), .mem_wr(mem_wr3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .mem_done(mem_done3), .busy(busy3),
    .ram_addr(ram_addr3), .ram_data(ram_data3), .ram_wr(ram_wr3), .ram_rdata(ram_rdata3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Unwritten memory words hold a recognisable function of their address.
  function automatic logic [15:0] init_word(input logic [17:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  logic [15:0] sram    [logic [17:0]];
  logic [15:0] mem_ref [logic [17:0]];

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    return sram.exists(a) ? sram[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : init_word(a);
  endfunction

  // SRAM driver stand-in: strobes and captures at the negedge.
  initial forever begin
    @(negedge clk);
    if (ram_wr === 1'b1) sram[ram_addr] = ram_data;
    else                 ram_rdata = sram_rd(ram_addr);
  end

  // Reference model: an access is a 3-cycle transaction counted from its grant.
  int          cyc = 0;
  bit          model_valid = 1'b0;
  logic        m_is_mem = 1'b0;
  logic        m_wr = 1'b0;
  logic [17:0] m_addr = 18'h0;
  logic [15:0] m_wdata = 16'h0;
  logic        exp_ram_wr = 1'b0, exp_if_done = 1'b0, exp_mem_done = 1'b0, exp_busy = 1'b0;
  logic [17:0] exp_ram_addr = 18'h0;
  logic [15:0] exp_ram_data = 16'h0, exp_if_rdata = 16'h0, exp_mem_rdata = 16'h0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      cyc = 0;
      exp_ram_wr = 1'b0; exp_if_done = 1'b0; exp_mem_done = 1'b0; exp_busy = 1'b0;
      exp_ram_addr = 18'h0; exp_ram_data = 16'h0; exp_if_rdata = 16'h0; exp_mem_rdata = 16'h0;
      model_valid = 1'b1;
    end else if (cyc == 0) begin
      if (mem_req || if_req) begin
        m_is_mem = mem_req;
        m_wr     = mem_req ? mem_wr : 1'b0;
        m_addr   = {2'b00, (mem_req ? mem_addr : if_addr)};
        m_wdata  = mem_wdata;
        if (mem_req) exp_ram_data = mem_wdata;
        exp_ram_addr = m_addr;
        exp_ram_wr   = m_wr;
        exp_busy     = 1'b1;
        cyc = 1;
      end
    end else if (cyc == 1) begin
      exp_ram_wr = 1'b0;
      if (m_wr)          mem_ref[m_addr] = m_wdata;
      else if (m_is_mem) exp_mem_rdata = ref_rd(m_addr);
      else               exp_if_rdata = ref_rd(m_addr);
      if (m_is_mem) exp_mem_done = 1'b1;
      else          exp_if_done = 1'b1;
      cyc = 2;
    end else begin
      exp_if_done = 1'b0; exp_mem_done = 1'b0; exp_busy = 1'b0;
      cyc = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      check("cmp_ram_wr",    32'(ram_wr),    32'(exp_ram_wr));
      check("cmp_ram_addr",  32'(ram_addr),  32'(exp_ram_addr));
      check("cmp_ram_data",  32'(ram_data),  32'(exp_ram_data));
      check("cmp_busy",      32'(busy),      32'(exp_busy));
      check("cmp_if_done",   32'(if_done),   32'(exp_if_done));
      check("cmp_mem_done",  32'(mem_done),  32'(exp_mem_done));
      check("cmp_if_rdata",  32'(if_rdata),  32'(exp_if_rdata));
      check("cmp_mem_rdata", 32'(mem_rdata), 32'(exp_mem_rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 6))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h0010;
      3:       return 16'h4000;
      4:       return 16'h8000;
      5:       return 16'hFFFF;
      default: return {8'h12, 8'($urandom)};
    endcase
  endfunction

  bit mem_hold = 1'b0;
  bit if_hold = 1'b0;

  initial begin
    // Reset held two cycles while a store is requested
    rst = 1'b1; mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h1111; mem_wdata = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_ram_wr",   32'(ram_wr),   32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_done",     32'({if_done, mem_done}), 32'h0);
      check("rst_busy",     32'(busy),     32'h0);
    end
    rst = 1'b0; mem_req = 1'b0;
    step();

    // Store BEEF to 0x4000
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h4000; mem_wdata = 16'hBEEF;
    step();
    check("st_ram_wr_c1",   32'(ram_wr),   32'h1);
    check("st_ram_addr_c1", 32'(ram_addr), 32'h04000);
    check("st_ram_data_c1", 32'(ram_data), 32'hBEEF);
    step();
    check("st_done_c2",     32'(mem_done), 32'h1);
    check("st_ram_wr_c2",   32'(ram_wr),   32'h0);
    mem_req = 1'b0;
    step();
    check("st_idle_c3",     32'({busy, mem_done}), 32'h0);

    // Load it back
    mem_req = 1'b1; mem_wr = 1'b0;
    step();
    check("ld_ram_wr_c1",   32'(ram_wr),   32'h0);
    step();
    check("ld_done_c2",     32'(mem_done),  32'h1);
    check("ld_rdata_c2",    32'(mem_rdata), 32'hBEEF);
    mem_req = 1'b0;
    step();

    // Simultaneous requests; IF is then held through its done cycle
    if_req = 1'b1; if_addr = 16'h0010;
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 16'h8000;
    step();
    check("sim_addr_c1",    32'(ram_addr),  32'h08000);
    step();
    check("sim_done_c2",    32'({if_done, mem_done}), 32'h1);
    check("sim_mrdata_c2",  32'(mem_rdata), 32'h25A5);
    mem_req = 1'b0;
    step();
    check("sim_idle_c3",    32'(busy),      32'h0);
    step();
    check("sim_addr_c4",    32'(ram_addr),  32'h00010);
    step();
    check("sim_ifdone_c5",  32'({if_done, mem_done}), 32'h2);
    check("sim_ifrdata_c5", 32'(if_rdata),  32'hA5B5);
    step();
    if_req = 1'b0;
    check("hold_c6",        32'({busy, if_done}), 32'h0);
    step();
    check("hold_c7",        32'({busy, if_done}), 32'h0);

    // Reset during the ACCESS cycle of a store
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 16'h7777; mem_wdata = 16'h1357;
    step();
    check("mr_ram_wr_c1",   32'(ram_wr),   32'h1);
    rst = 1'b1; mem_req = 1'b0;
    step();
    check("mr_after",       32'({busy, ram_wr, mem_done}), 32'h0);
    check("mr_ram_addr",    32'(ram_addr), 32'h0);
    rst = 1'b0;
    step();
    check("mr_no_done",     32'(mem_done), 32'h0);

    // Address extension 2'b11 at the top CPU address
    mem_req3 = 1'b1; mem_wr3 = 1'b0; mem_addr3 = 16'hFFFF;
    step();
    check("ext_ram_addr",   32'(ram_addr3), 32'h3FFFF);
    step();
    check("ext_done",       32'(mem_done3),  32'h1);
    check("ext_rdata",      32'(mem_rdata3), 32'h1234);
    mem_req3 = 1'b0;
    step();

    // Randomized traffic from two well-behaved requesters
    for (int n = 0; n < 3000; n++) begin
      if (mem_done) begin
        if ($urandom_range(0, 1) == 0) mem_req = 1'b0;
        else mem_hold = 1'b1;
      end else if (mem_hold) begin
        mem_req = 1'b0; mem_hold = 1'b0;
      end else if (!mem_req) begin
        if (!(cyc != 0 && m_is_mem) && $urandom_range(0, 3) == 0) begin
          mem_req = 1'b1; mem_wr = 1'($urandom); mem_addr = pick_addr(); mem_wdata = 16'($urandom);
        end
      end else if (cyc != 0 && m_is_mem && $urandom_range(0, 19) == 0) begin
        mem_req = 1'b0;
      end

      if (if_done) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0;
        else if_hold = 1'b1;
      end else if (if_hold) begin
        if_req = 1'b0; if_hold = 1'b0;
      end else if (!if_req) begin
        if (!(cyc != 0 && !m_is_mem) && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = pick_addr();
        end
      end else if (cyc != 0 && !m_is_mem && $urandom_range(0, 19) == 0) begin
        if_req = 1'b0;
      end
      step();
    end

    mem_req = 1'b0; if_req = 1'b0;
    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
